// File: rtl/ws2811_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ws2811_pkg
//   Shared definitions for the WS2811 line decoder and its encoder twin.
//   - Decoder FSM state codes (SYNC, LOW, HIGH).
//   - Nominal WS2811 timing at 60 MHz, in clk cycles.
//   - Default decode thresholds used by the decoder parameters.
//   - Saturating 16-bit increment shared by the cycle and byte counters.
// -----------------------------------------------------------------------------
package ws2811_pkg;

  // Decoder FSM state codes.
  localparam logic [1:0] ST_SYNC = 2'd0;  // waiting for a full latch gap
  localparam logic [1:0] ST_LOW  = 2'd1;  // line low between bits
  localparam logic [1:0] ST_HIGH = 2'd2;  // measuring a high pulse

  // Nominal encoder timing at 60 MHz (clk cycles).
  localparam int T0H_CYC    = 18;    // high time of a '0'
  localparam int T1H_CYC    = 42;    // high time of a '1'
  localparam int TBIT_CYC   = 75;    // full bit period
  localparam int TRESET_CYC = 3000;  // latch/reset gap (50 us)

  // Default decode thresholds (clk cycles).
  localparam int TH_MIN_CYC = 6;     // shorter highs are glitches
  localparam int T1_MIN_CYC = 33;    // '1' at or above this width
  localparam int TH_MAX_CYC = 90;    // longer highs are timeouts

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ws2811_decoder_sync_2ff.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-stage synchronizer for a single asynchronous bit. Both stages clear to
//   0 on reset so the decoder sees an idle (low) line coming out of reset.
//
// Ports
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   d    in   asynchronous input
//   q    out  synchronized copy of d, two clk edges later
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so both stages sample the
    // pre-edge values; blocking here would collapse the chain into one stage.
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2811_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ws2811_decoder
//   Recovers bytes from a WS2811 single-wire stream by measuring each high
//   pulse with the system clock. Bits arrive MSB first; eight bits make a byte.
//   A long low period (latch gap) closes the frame.
//
// Ports
//   clk          in   60 MHz system clock, rising edge only
//   rst          in   synchronous, active-high reset
//   din          in   asynchronous WS2811 serial line
//   data_out     out  [7:0]  last decoded byte, held until the next one
//   data_valid   out  one-cycle pulse, data_out carries a new byte
//   frame_end    out  one-cycle pulse, latch gap after at least one byte
//   bit_error    out  one-cycle pulse, glitch, timeout or partial byte at gap
//   frame_bytes  out  [15:0] bytes decoded in this frame, saturating
//
// Latency: data_valid rises 4 clk edges after din falls on the 8th bit
// (2 synchronizer stages, 1 decode stage, 1 output stage).
// -----------------------------------------------------------------------------
module ws2811_decoder
  import ws2811_pkg::*;
#(
  parameter int TH_MIN = TH_MIN_CYC,
  parameter int T1_MIN = T1_MIN_CYC,
  parameter int TH_MAX = TH_MAX_CYC,
  parameter int TRESET = TRESET_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        frame_end,
  output logic        bit_error,
  output logic [15:0] frame_bytes
);

  // Thresholds at counter width so every compare is 16 bits on both sides.
  localparam logic [15:0] TH_MIN_W   = 16'(TH_MIN);
  localparam logic [15:0] T1_MIN_W   = 16'(T1_MIN);
  localparam logic [15:0] TH_MAX_W   = 16'(TH_MAX);
  localparam logic [15:0] GAP_LAST_W = 16'(TRESET - 1);

  logic        ds;          // synchronized din
  logic        ds_d;        // ds one cycle earlier, for edge detection
  logic        rise;
  logic        fall;
  logic [1:0]  state;
  logic [15:0] cnt;         // shared run-length counter
  logic [15:0] cnt_inc;
  logic        width_ok;    // high width is a legal bit
  logic        bit_val;     // decoded value for a legal width
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        byte_done;   // 8th bit just shifted in; publish next cycle
  logic        fb_clear;    // latch pulse just issued; clear frame_bytes next

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (ds)
  );

  always_comb begin
    // NOTE: every signal driven here is assigned on all paths, so no latch is
    // inferred; keep it that way when adding conditions.
    rise     = ds & ~ds_d;
    fall     = ~ds & ds_d;
    cnt_inc  = sat_inc16(cnt);
    // In HIGH, cnt equals the number of high cycles seen so far, so on the
    // falling-edge cycle it is exactly the pulse width.
    width_ok = (cnt >= TH_MIN_W) && (cnt <= TH_MAX_W);
    bit_val  = (cnt >= T1_MIN_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_d        <= 1'b0;
      state       <= ST_SYNC;
      cnt         <= 16'd0;
      shift_reg   <= 8'd0;
      bit_idx     <= 3'd0;
      byte_done   <= 1'b0;
      fb_clear    <= 1'b0;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      frame_end   <= 1'b0;
      bit_error   <= 1'b0;
      frame_bytes <= 16'd0;
    end else begin
      ds_d       <= ds;
      byte_done  <= 1'b0;
      fb_clear   <= 1'b0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      bit_error  <= 1'b0;

      // Output stage. A completed byte and a latch clear are thousands of
      // cycles apart, so the two branches never compete.
      if (byte_done) begin
        data_out    <= shift_reg;
        data_valid  <= 1'b1;
        frame_bytes <= sat_inc16(frame_bytes);
      end else if (fb_clear) begin
        frame_bytes <= 16'd0;
      end

      case (state)
        // Hunt for a full latch gap before trusting any edge; this is how the
        // decoder regains framing after reset or a line error.
        ST_SYNC: begin
          if (ds) begin
            cnt <= 16'd0;
          end else if (cnt == GAP_LAST_W) begin
            state <= ST_LOW;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= 16'd1;  // the rising-edge cycle is the first high cycle
          end else begin
            // cnt saturates, so the gap action below fires once per gap.
            cnt <= cnt_inc;
            if (cnt == GAP_LAST_W) begin
              if (bit_idx != 3'd0) begin
                bit_error <= 1'b1;
                fb_clear  <= 1'b1;
              end else if (frame_bytes != 16'd0) begin
                frame_end <= 1'b1;
                fb_clear  <= 1'b1;
              end
              bit_idx   <= 3'd0;
              shift_reg <= 8'd0;
            end
          end
        end

        ST_HIGH: begin
          if (fall) begin
            if (width_ok) begin
              state     <= ST_LOW;
              cnt       <= 16'd1;  // the falling-edge cycle is already low
              shift_reg <= {shift_reg[6:0], bit_val};
              bit_idx   <= bit_idx + 3'd1;
              byte_done <= (bit_idx == 3'd7);
            end else begin
              // Glitch: drop the partial byte and resynchronize. frame_bytes
              // is kept so the count survives until the next latch gap.
              state     <= ST_SYNC;
              cnt       <= 16'd1;
              bit_error <= 1'b1;
              bit_idx   <= 3'd0;
              shift_reg <= 8'd0;
            end
          end else if (cnt == TH_MAX_W) begin
            // This high cycle would make the width TH_MAX+1: timeout.
            state     <= ST_SYNC;
            cnt       <= 16'd0;
            bit_error <= 1'b1;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= ST_SYNC;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ws2811_decoder
//   Directed bench for ws2811_decoder. Expected bytes go into a queue as they
//   are driven; a negedge monitor pops and compares on every data_valid and
//   counts the three pulse outputs for the directed steps to check.
// -----------------------------------------------------------------------------
module tb_ws2811_decoder;

  localparam int GAP   = 3010;  // comfortably longer than a 3000-cycle latch
  localparam int T1MIN = 33;    // decode threshold for '1'

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        frame_end;
  logic        bit_error;
  logic [15:0] frame_bytes;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  int dv_cnt = 0, fe_cnt = 0, be_cnt = 0;
  int dv_cyc = 0, be_cyc = 0;
  int fb_at_fe = -1;
  int fall_cyc = 0;

  ws2811_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_end   (frame_end),
    .bit_error   (bit_error),
    .frame_bytes (frame_bytes)
  );

  always #8 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid || frame_end || bit_error)
      check("pulse_overlap", {30'd0, data_valid & frame_end, data_valid & bit_error}, 32'd0);
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      if (byte_q.size() == 0) check("unexpected_data_valid", 32'd1, 32'd0);
      else check("data_out", {24'd0, data_out}, {24'd0, byte_q.pop_front()});
    end
    if (frame_end) begin
      fe_cnt++;
      fb_at_fe = int'(frame_bytes);
    end
    if (bit_error) begin
      be_cnt++;
      be_cyc = cyc;
    end
  end

  // All drivers run at posedge+1 so each call leaves that alignment intact.
  task automatic low(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int high_w, input int low_w);
    din = 1'b1;
    repeat (high_w) @(posedge clk);
    #1;
    din = 1'b0;
    fall_cyc = cyc;
    repeat (low_w) @(posedge clk);
    #1;
  endtask

  // Sends bits [7:8-nbits] of b at nominal timing; pushes b if asked.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit push);
    if (push) byte_q.push_back(b);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (b[i]) drive_bit(42, 33);
      else      drive_bit(18, 57);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int dv0, fe0, be0, rise_cyc;
  int w_tab[8] = '{6, 33, 32, 90, 18, 42, 6, 90};
  logic [7:0] exp_b;

  initial begin
    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_pulses", {29'd0, data_valid, frame_end, bit_error}, 32'd0);
    check("rst_frame_bytes", {16'd0, frame_bytes}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_outputs", {data_out, data_valid, frame_end, bit_error, 5'd0, frame_bytes}, 32'd0);

    // Single byte 0xA5 framed by latch gaps; latency from the 8th falling edge.
    low(GAP);
    send_bits(8'hA5, 8, 1'b1);
    check("a5_dv_count", dv_cnt, 1);
    check("a5_latency", dv_cyc - fall_cyc, 4);
    check("a5_frame_bytes", {16'd0, frame_bytes}, 32'd1);
    low(GAP);
    check("a5_frame_end", fe_cnt, 1);
    check("a5_fb_at_frame_end", fb_at_fe, 1);
    check("a5_fb_cleared", {16'd0, frame_bytes}, 32'd0);
    check("a5_no_bit_error", be_cnt, 0);

    // Three back-to-back bytes.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bits(8'hFF, 8, 1'b1);
    send_bits(8'h00, 8, 1'b1);
    send_bits(8'h81, 8, 1'b1);
    check("grb_frame_bytes", {16'd0, frame_bytes}, 32'd3);
    low(GAP);
    check("grb_dv_count", dv_cnt - dv0, 3);
    check("grb_frame_end", fe_cnt - fe0, 1);
    check("grb_fb_at_frame_end", fb_at_fe, 3);
    check("grb_queue_empty", byte_q.size(), 0);

    // Width boundaries: 6 (shortest '0'), 32/33 around the '1' threshold, 90.
    dv0 = dv_cnt; be0 = be_cnt;
    exp_b = 8'd0;
    foreach (w_tab[i]) exp_b = {exp_b[6:0], (w_tab[i] >= T1MIN)};
    byte_q.push_back(exp_b);
    foreach (w_tab[i]) drive_bit(w_tab[i], 30);
    low(GAP);
    check("edge_dv_count", dv_cnt - dv0, 1);
    check("edge_no_bit_error", be_cnt - be0, 0);

    // Glitch after four good bits, then recovery after a latch gap.
    dv0 = dv_cnt; fe0 = fe_cnt; be0 = be_cnt;
    send_bits(8'hF0, 4, 1'b0);
    drive_bit(3, 20);
    low(GAP);
    check("glitch_bit_error", be_cnt - be0, 1);
    check("glitch_no_dv", dv_cnt - dv0, 0);
    check("glitch_no_frame_end", fe_cnt - fe0, 0);
    send_bits(8'h5A, 8, 1'b1);
    low(GAP);
    check("glitch_recover_dv", dv_cnt - dv0, 1);
    check("glitch_recover_fe", fe_cnt - fe0, 1);

    // Timeout: line held high 100 cycles after a good byte.
    dv0 = dv_cnt; fe0 = fe_cnt; be0 = be_cnt;
    send_bits(8'h11, 8, 1'b1);
    din = 1'b1;
    rise_cyc = cyc;
    repeat (100) @(posedge clk);
    #1;
    low(GAP);
    check("timeout_bit_error", be_cnt - be0, 1);
    check("timeout_error_cycle", be_cyc - rise_cyc, 93);
    check("timeout_no_frame_end", fe_cnt - fe0, 0);
    check("timeout_dv", dv_cnt - dv0, 1);

    // Partial byte (5 bits) at a latch gap.
    fe0 = fe_cnt; be0 = be_cnt; dv0 = dv_cnt;
    send_bits(8'hE8, 5, 1'b0);
    low(GAP);
    check("partial_bit_error", be_cnt - be0, 1);
    check("partial_no_frame_end", fe_cnt - fe0, 0);
    check("partial_no_dv", dv_cnt - dv0, 0);
    @(posedge clk);
    #1;
    check("partial_fb_cleared", {16'd0, frame_bytes}, 32'd0);

    // Reset mid-byte, then 0x3C with no leading gap must be ignored.
    fe0 = fe_cnt; be0 = be_cnt; dv0 = dv_cnt;
    send_bits(8'h3C, 4, 1'b0);
    pulse_reset();
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_frame_bytes", {16'd0, frame_bytes}, 32'd0);
    send_bits(8'h3C, 8, 1'b0);
    low(100);
    check("midrst_no_dv", dv_cnt - dv0, 0);
    check("midrst_no_pulses", (fe_cnt - fe0) + (be_cnt - be0), 0);
    low(GAP);
    send_bits(8'h3C, 8, 1'b1);
    low(GAP);
    check("midrst_resume_dv", dv_cnt - dv0, 1);
    check("midrst_resume_fe", fe_cnt - fe0, 1);
    check("final_queue_empty", byte_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
